// File: rtl/eship_projectile_pool_if.sv
// Bus between the projectile finder, collision logic, renderer and the enemy projectile pool.
// PlayerX is present only when EPROJ_AIM_EN is defined.
interface eship_projectile_pool_if #(
  parameter int NPE = 4
);
  localparam int CNT_W = $clog2(NPE + 1);

  logic [NPE-1:0]      EProjActvt;
  logic [9:0]          SpawnX;
  logic [9:0]          SpawnY;
  logic [NPE-1:0]      EProjHit;
`ifdef EPROJ_AIM_EN
  logic [9:0]          PlayerX;
`endif
  logic [NPE-1:0]      EProjEn;
  logic [NPE*10-1:0]   EProjX;
  logic [NPE*10-1:0]   EProjY;
  logic [CNT_W-1:0]    EProjCount;

  modport master (
`ifdef EPROJ_AIM_EN
    output PlayerX,
`endif
    output EProjActvt, SpawnX, SpawnY, EProjHit,
    input  EProjEn, EProjX, EProjY, EProjCount
  );

  modport slave (
`ifdef EPROJ_AIM_EN
    input  PlayerX,
`endif
    input  EProjActvt, SpawnX, SpawnY, EProjHit,
    output EProjEn, EProjX, EProjY, EProjCount
  );
endinterface

// File: rtl/eship_projectile_pool.sv
// Enemy projectile slot pool: loads spawn positions on one-hot activation and moves live shots down each frame.
// Optional aimed horizontal drift is enabled by defining EPROJ_AIM_EN.
module eship_projectile_pool #(
  parameter int NPE   = 4,
  parameter int SPEED = 4,
  parameter int Y_MAX = 479,
  parameter int X_MAX = 639
) (
  input  logic             frame_clk,
  input  logic             Reset,
  eship_projectile_pool_if.slave bus
);
  localparam int CNT_W = $clog2(NPE + 1);
  localparam logic [10:0] Y_LIM = 11'(Y_MAX);
  localparam logic [10:0] Y_STEP = 11'(SPEED);

  typedef enum logic {FREE = 1'b0, LIVE = 1'b1} slotState_t;

`ifdef EPROJ_AIM_EN
  typedef enum logic [1:0] {STRAIGHT = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} aimDir_t;
  localparam logic signed [10:0] X_LIM = 11'(X_MAX);

  aimDir_t    slotDir     [NPE];
  aimDir_t    slotDirNext [NPE];
  logic signed [10:0] xTry;
`endif

  slotState_t slotState     [NPE];
  slotState_t slotStateNext [NPE];
  logic [9:0] posX     [NPE];
  logic [9:0] posY     [NPE];
  logic [9:0] posXNext [NPE];
  logic [9:0] posYNext [NPE];

  logic [NPE-1:0] actFirst;
  logic           spawnOk;
  logic [10:0]    yTry;

  // Isolate the lowest set request bit; higher simultaneous requests are dropped.
  assign actFirst = bus.EProjActvt & (~bus.EProjActvt + 1'b1);
  assign spawnOk  = ({1'b0, bus.SpawnY} <= Y_LIM);

  // NOTE: every always_comb output gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    yTry = '0;
`ifdef EPROJ_AIM_EN
    xTry = '0;
`endif
    for (int i = 0; i < NPE; i++) begin
      slotStateNext[i] = slotState[i];
      posXNext[i]      = posX[i];
      posYNext[i]      = posY[i];
`ifdef EPROJ_AIM_EN
      slotDirNext[i]   = slotDir[i];
`endif
      if (slotState[i] == FREE) begin
        if (actFirst[i] && spawnOk) begin
          slotStateNext[i] = LIVE;
          posXNext[i]      = bus.SpawnX;
          posYNext[i]      = bus.SpawnY;
`ifdef EPROJ_AIM_EN
          if (bus.PlayerX < bus.SpawnX)      slotDirNext[i] = LEFT;
          else if (bus.PlayerX > bus.SpawnX) slotDirNext[i] = RIGHT;
          else                               slotDirNext[i] = STRAIGHT;
`endif
        end
      end else begin
        yTry = {1'b0, posY[i]} + Y_STEP;
`ifdef EPROJ_AIM_EN
        case (slotDir[i])
          LEFT:    xTry = $signed({1'b0, posX[i]}) - 11'sd1;
          RIGHT:   xTry = $signed({1'b0, posX[i]}) + 11'sd1;
          default: xTry = $signed({1'b0, posX[i]});
        endcase
`endif
        if (bus.EProjHit[i]) begin
          slotStateNext[i] = FREE;
        end else if (yTry > Y_LIM) begin
          slotStateNext[i] = FREE;
`ifdef EPROJ_AIM_EN
        end else if (xTry < 11'sd0 || xTry > X_LIM) begin
          slotStateNext[i] = FREE;
        end else begin
          posYNext[i] = yTry[9:0];
          posXNext[i] = xTry[9:0];
        end
`else
        end else begin
          posYNext[i] = yTry[9:0];
        end
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all slots update from the same pre-edge values.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      for (int i = 0; i < NPE; i++) begin
        slotState[i] <= FREE;
        posX[i]      <= '0;
        posY[i]      <= '0;
`ifdef EPROJ_AIM_EN
        slotDir[i]   <= STRAIGHT;
`endif
      end
    end else begin
      for (int i = 0; i < NPE; i++) begin
        slotState[i] <= slotStateNext[i];
        posX[i]      <= posXNext[i];
        posY[i]      <= posYNext[i];
`ifdef EPROJ_AIM_EN
        slotDir[i]   <= slotDirNext[i];
`endif
      end
    end
  end

  logic [NPE-1:0]    enVec;
  logic [NPE*10-1:0] xVec;
  logic [NPE*10-1:0] yVec;
  logic [CNT_W-1:0]  liveCount;

  always_comb begin
    enVec     = '0;
    xVec      = '0;
    yVec      = '0;
    liveCount = '0;
    for (int i = 0; i < NPE; i++) begin
      enVec[i]        = (slotState[i] == LIVE);
      xVec[10*i +: 10] = posX[i];
      yVec[10*i +: 10] = posY[i];
      liveCount       = liveCount + CNT_W'(enVec[i]);
    end
  end

  assign bus.EProjEn    = enVec;
  assign bus.EProjX     = xVec;
  assign bus.EProjY     = yVec;
  assign bus.EProjCount = liveCount;

endmodule

// File: tb/tb_eship_projectile_pool.sv
// Directed bench for eship_projectile_pool; aimed-drift vectors run only when EPROJ_AIM_EN is defined.
module tb_eship_projectile_pool;
  localparam int NPE = 4;

  logic frame_clk = 1'b0;
  logic Reset;
  int   nChecks = 0;
  int   nPass   = 0;

  eship_projectile_pool_if #(.NPE(NPE)) bus ();

  eship_projectile_pool #(.NPE(NPE), .SPEED(4), .Y_MAX(479), .X_MAX(639)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed === expected) nPass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Inputs are changed between edges; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  function automatic logic [31:0] slotX(input int i);
    return 32'(bus.EProjX[10*i +: 10]);
  endfunction

  function automatic logic [31:0] slotY(input int i);
    return 32'(bus.EProjY[10*i +: 10]);
  endfunction

  task automatic doReset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic load(input logic [3:0] act, input logic [9:0] x, input logic [9:0] y);
    bus.EProjActvt = act;
    bus.SpawnX     = x;
    bus.SpawnY     = y;
    step();
    bus.EProjActvt = '0;
  endtask

  initial begin
    Reset          = 1'b0;
    bus.EProjActvt = '0;
    bus.EProjHit   = '0;
    bus.SpawnX     = '0;
    bus.SpawnY     = '0;
`ifdef EPROJ_AIM_EN
    bus.PlayerX    = '0;
`endif
    #2;

    // Reset state
    doReset();
    check("rst_en",  32'(bus.EProjEn), 32'd0);
    check("rst_cnt", 32'(bus.EProjCount), 32'd0);
    check("rst_x",   32'(bus.EProjX), 32'd0);
    check("rst_y",   32'(bus.EProjY), 32'd0);

    // Basic load and first move
    load(4'b0001, 10'd100, 10'd50);
    check("load_en", 32'(bus.EProjEn), 32'b0001);
    check("load_x0", slotX(0), 32'd100);
    check("load_y0", slotY(0), 32'd50);
    check("load_cnt", 32'(bus.EProjCount), 32'd1);
    step();
    check("move_y0", slotY(0), 32'd54);
    check("move_x0", slotX(0), 32'd100);
    check("move_cnt", 32'(bus.EProjCount), 32'd1);

    // Bottom edge: 475 -> 479 stays live, next step retires
    doReset();
    load(4'b0001, 10'd20, 10'd475);
    step();
    check("edge479_y", slotY(0), 32'd479);
    check("edge479_en", 32'(bus.EProjEn), 32'b0001);
    step();
    check("edge_ret_en", 32'(bus.EProjEn), 32'd0);
    check("edge_ret_y", slotY(0), 32'd479);

    // Y=476 retires on next edge, position holds, reload on following edge
    load(4'b0001, 10'd30, 10'd476);
    check("y476_en", 32'(bus.EProjEn), 32'b0001);
    step();
    check("y476_ret_en", 32'(bus.EProjEn), 32'd0);
    check("y476_ret_y", slotY(0), 32'd476);
    load(4'b0001, 10'd40, 10'd100);
    check("reload_en", 32'(bus.EProjEn), 32'b0001);
    check("reload_y", slotY(0), 32'd100);
    check("reload_x", slotX(0), 32'd40);

    // Multiple request bits: only the lowest honoured
    doReset();
    load(4'b0110, 10'd7, 10'd10);
    check("multi_en", 32'(bus.EProjEn), 32'b0010);
    check("multi_x1", slotX(1), 32'd7);
    check("multi_y1", slotY(1), 32'd10);
    check("multi_y2", slotY(2), 32'd0);
    // Activation of a live slot is ignored
    load(4'b0010, 10'd300, 10'd300);
    check("live_act_y1", slotY(1), 32'd14);
    check("live_act_x1", slotX(1), 32'd7);

    // Hit beats continued motion; activation of that still-live slot ignored
    doReset();
    load(4'b0100, 10'd60, 10'd196);
    step();
    check("hit_pre_y2", slotY(2), 32'd200);
    bus.EProjHit   = 4'b0100;
    bus.EProjActvt = 4'b0100;
    bus.SpawnY     = 10'd50;
    step();
    bus.EProjHit   = '0;
    check("hit_en", 32'(bus.EProjEn), 32'd0);
    check("hit_y2", slotY(2), 32'd200);
    step();
    check("hit_reload_en", 32'(bus.EProjEn), 32'b0100);
    check("hit_reload_y2", slotY(2), 32'd50);
    // Hit on a free slot with activation: activation wins
    bus.EProjHit = 4'b0001;
    load(4'b0001, 10'd5, 10'd5);
    bus.EProjHit = '0;
    check("freehit_en", 32'(bus.EProjEn), 32'b0101);
    check("freehit_y0", slotY(0), 32'd5);

    // Fill all slots, then reset (with a pending activation) clears everything
    load(4'b0010, 10'd11, 10'd20);
    load(4'b1000, 10'd12, 10'd30);
    check("full_en", 32'(bus.EProjEn), 32'b1111);
    check("full_cnt", 32'(bus.EProjCount), 32'd4);
    bus.EProjActvt = 4'b0001;
    bus.SpawnY     = 10'd10;
    doReset();
    bus.EProjActvt = '0;
    check("midrst_en", 32'(bus.EProjEn), 32'd0);
    check("midrst_cnt", 32'(bus.EProjCount), 32'd0);
    check("midrst_x", 32'(bus.EProjX), 32'd0);
    check("midrst_y", 32'(bus.EProjY), 32'd0);

    // Spawn below the visible area is refused
    load(4'b0001, 10'd10, 10'd480);
    check("spawn480_en", 32'(bus.EProjEn), 32'd0);
    load(4'b0001, 10'd10, 10'd479);
    check("spawn479_en", 32'(bus.EProjEn), 32'b0001);

`ifdef EPROJ_AIM_EN
    doReset();
    bus.PlayerX = 10'd300;
    load(4'b0001, 10'd1, 10'd10);
    check("aim_load_x", slotX(0), 32'd1);
    step();
    check("aim_x1", slotX(0), 32'd2);
    step();
    check("aim_x2", slotX(0), 32'd3);
    doReset();
    bus.PlayerX = 10'd0;
    load(4'b0001, 10'd0, 10'd10);
    step();
    check("aim_str_x", slotX(0), 32'd0);
    step();
    check("aim_str_x2", slotX(0), 32'd0);
    check("aim_str_en", 32'(bus.EProjEn), 32'b0001);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/eship_projectile_pool.md
Name: eship_projectile_pool

Overview:
- Holds NPE enemy projectile slots. Sits directly downstream of the enemy projectile finder and consumes its one-hot activation vector.
- On activation, loads the spawn position of the firing ship into a free slot, then advances each live projectile down the screen once per frame.
- Retires a projectile at the bottom edge or on a collision hit.
- Drives the per-slot enable vector back to the finder, which uses it to pick free slots, and drives slot positions to the renderer and collision logic.

Parameters:
- NPE, 4: number of projectile slots. Matches the galaga_lib value.
- SPEED, 4: Y pixels advanced per frame, range 1..15.
- Y_MAX, 479: last visible row. A projectile whose next Y exceeds this is retired.
- X_MAX, 639: last visible column. Used only by the optional feature.

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- EProjActvt  in  NPE  one-hot slot activation request from the finder.
- SpawnX  in  10  X of the firing ship, sampled on activation.
- SpawnY  in  10  Y of the firing ship, sampled on activation.
- EProjHit  in  NPE  per-slot collision clear from collision logic.
- EProjEn  out  NPE  slot-live flags, registered.
- EProjX  out  NPE*10  packed slot X; slot i occupies bits [10i+9:10i]. Registered.
- EProjY  out  NPE*10  packed slot Y, same packing. Registered.
- EProjCount  out  $clog2(NPE+1)  popcount of EProjEn. Combinational from the registered EProjEn.

Behaviour:
- Reset: synchronous, active-high, sampled on frame_clk. The clock and reset are the only clocking signals.
  - Reset values: EProjEn=0, all EProjX=0, all EProjY=0, EProjCount=0, direction regs=0.
  - Reset wins over every other input in the same cycle.
  - Asserting Reset mid-flight kills all projectiles on the next edge.
- Per-slot state is two-state: FREE (EProjEn[i]=0) and LIVE (EProjEn[i]=1). Each slot updates independently every edge.
- FREE slot, activation taken:
  - Condition: EProjActvt[i]=1, i is the lowest set bit of EProjActvt, and SpawnY <= Y_MAX.
  - Action: go LIVE; X<=SpawnX, Y<=SpawnY.
- FREE slot, activation not taken: stays FREE; X and Y hold their last values.
- Multiple EProjActvt bits set: only the lowest set bit is honoured. Higher bits are ignored, with no error.
- Activation of a LIVE slot is ignored; position and motion are unaffected. This makes a request held for several frames harmless.
- LIVE slot, priority order on each edge:
  1. EProjHit[i]=1: go FREE. Position holds.
  2. Y+SPEED > Y_MAX: go FREE. Position holds.
  3. Otherwise: Y<=Y+SPEED; X holds (base build).
- Y+SPEED is computed in 11 bits, so there is no wrap near 1023.
- EProjHit[i] on a FREE slot is ignored. A hit and an activation on the same FREE slot in the same cycle: the activation wins.
- A slot freed on edge N is visible as free on EProjEn after edge N and may be reactivated on edge N+1.
- Latency:
  - Activation to live, with valid position on outputs: 1 frame_clk.
  - First movement: the edge after load.
  - Retire to EProjEn low: 1 frame_clk.

Optional Feature:
- Macro: EPROJ_AIM_EN.
- Defined:
  - Adds input PlayerX, 10 bits.
  - On load, slot i latches a 2-bit direction: left if PlayerX<SpawnX, right if PlayerX>SpawnX, straight if equal.
  - While LIVE, X moves 1 pixel per frame in the latched direction, alongside the Y step.
  - The slot retires (priority 2b, after bottom-edge retire) if the next X would be <0 or >X_MAX. X arithmetic is 11-bit signed.
- Undefined: no PlayerX port, no direction registers; X is constant while LIVE.

Test Plan:
- Reset, then EProjActvt=0001, SpawnX=100, SpawnY=50 for one edge -> next edge EProjEn=0001, slot0 X=100, Y=50; following edge Y=54, EProjCount=1.
- Slot0 live at Y=476 with SPEED=4 -> next edge EProjEn[0]=0 and Y stays 476; EProjActvt=0001 on the following edge reloads slot0.
- EProjActvt=0110 with all slots free, SpawnY=10 -> only slot1 goes live; slot2 stays free.
- Slot2 live at Y=200, EProjHit=0100 and EProjActvt=0100 on the same edge -> slot2 freed and not reloaded; EProjActvt=0100 on the next edge loads it.
- All four slots live, Reset asserted for one edge -> EProjEn=0, all X/Y=0, EProjCount=0. SpawnY=480 with EProjActvt=0001 -> slot0 stays free.
- EPROJ_AIM_EN defined: SpawnX=1, PlayerX=300, activate slot0 -> X=2 after the first move edge, X=3 after the second. SpawnX=0, PlayerX=0 -> X stays 0.
